// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared types and constants for the data-memory responder
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } mem_state_t;

    localparam int WORD_BYTES = 4;
    localparam int ADDR_LSB   = 2;

endpackage

// File: rtl/wait_counter.sv
// rtl/wait_counter.sv - 4-bit loadable down-counter for wait-state insertion
//
// Ports:
//   clk_i       clock, rising edge
//   rst_ni      asynchronous active-low reset, clears the count
//   load_i      load load_val_i (takes priority over en_i)
//   load_val_i  value to load
//   en_i        decrement by one while the count is non-zero
//   zero_o      count is zero
module wait_counter (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       load_i,
    input  logic [3:0] load_val_i,
    input  logic       en_i,
    output logic       zero_o
);

    logic [3:0] count_q;
    logic [3:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (en_i && (count_q != 4'd0)) begin
            count_d = count_q - 4'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= 4'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero_o = (count_q == 4'd0);

endmodule

// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - wait-state data-memory responder with done/fail monitor
//
// Ports:
//   clk        clock, rising edge
//   reset      asynchronous active-low reset
//   req_valid  request present          req_write  1 = store, 0 = load
//   req_addr   byte address             req_wdata  store data
//   req_ready  request accepted this cycle when high together with req_valid
//   rsp_valid  one-cycle response pulse
//   rsp_rdata  load data (0 for stores and errors), held until next commit
//   rsp_err    misaligned or out-of-range access, held until next commit
//   done       sticky: DONE_DATA stored to DONE_ADDR
//   fail       sticky: other data stored to DONE_ADDR, or any store error
//   wr_count   committed stores, saturating at 8'hFF
module data_mem_responder
    import mem_pkg::*;
#(
    parameter int          DEPTH_WORDS = 64,
    parameter int          WAIT_CYCLES = 1,
    parameter logic [31:0] DONE_ADDR   = 32'h64,
    parameter logic [31:0] DONE_DATA   = 32'hA
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        req_ready,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        done,
    output logic        fail,
    output logic [7:0]  wr_count
);

    localparam int         IDX_W    = $clog2(DEPTH_WORDS);
    // WAIT_CYCLES==0 never enters WAIT, so the load value is irrelevant there.
    localparam logic [3:0] CNT_LOAD = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    logic [31:0] ram [DEPTH_WORDS];

    mem_state_t  state_q;
    logic        req_ready_q, rsp_valid_q, rsp_err_q, done_q, fail_q;
    logic [31:0] rsp_rdata_q;
    logic [7:0]  wr_count_q;
    logic        wr_q;
    logic [31:0] addr_q, wdata_q;

    logic        accept, commit, cnt_zero;
    logic        c_write, c_err;
    logic [31:0] c_addr, c_wdata, rd_word;
    logic [IDX_W-1:0] c_idx;

    assign accept = (state_q == IDLE) && req_ready_q && req_valid;

    // Commit on the edge entering RESP. With no wait states that edge is the
    // acceptance edge itself, so the live request is used instead of the capture.
    assign commit  = ((state_q == WAIT) && cnt_zero) || ((WAIT_CYCLES == 0) && accept);
    assign c_write = (state_q == IDLE) ? req_write : wr_q;
    assign c_addr  = (state_q == IDLE) ? req_addr  : addr_q;
    assign c_wdata = (state_q == IDLE) ? req_wdata : wdata_q;
    assign c_err   = (c_addr[ADDR_LSB-1:0] != '0) ||
                     (c_addr[31:ADDR_LSB] >= (32-ADDR_LSB)'(DEPTH_WORDS));
    assign c_idx   = c_addr[ADDR_LSB +: IDX_W];
    assign rd_word = ram[c_idx];

    wait_counter u_wait_counter (
        .clk_i      (clk),
        .rst_ni     (reset),
        .load_i     (accept),
        .load_val_i (CNT_LOAD),
        .en_i       (state_q == WAIT),
        .zero_o     (cnt_zero)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'd0;
            rsp_err_q   <= 1'b0;
            done_q      <= 1'b0;
            fail_q      <= 1'b0;
            wr_count_q  <= 8'd0;
            wr_q        <= 1'b0;
            addr_q      <= 32'd0;
            wdata_q     <= 32'd0;
        end else begin
            rsp_valid_q <= commit;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        wr_q        <= req_write;
                        addr_q      <= req_addr;
                        wdata_q     <= req_wdata;
                        req_ready_q <= 1'b0;
                        state_q     <= (WAIT_CYCLES == 0) ? RESP : WAIT;
                    end else begin
                        req_ready_q <= 1'b1;
                    end
                end
                WAIT: begin
                    if (cnt_zero) begin
                        state_q <= RESP;
                    end
                end
                RESP: begin
                    state_q     <= IDLE;
                    req_ready_q <= 1'b1;
                end
                default: begin
                    state_q     <= IDLE;
                    req_ready_q <= 1'b0;
                end
            endcase

            if (commit) begin
                rsp_err_q   <= c_err;
                rsp_rdata_q <= (!c_write && !c_err) ? rd_word : 32'd0;
                if (c_write) begin
                    if (c_err) begin
                        fail_q <= 1'b1;
                    end else begin
                        if (wr_count_q != 8'hFF) begin
                            wr_count_q <= wr_count_q + 8'd1;
                        end
                        if (c_addr == DONE_ADDR) begin
                            if (c_wdata == DONE_DATA) begin
                                done_q <= 1'b1;
                            end else begin
                                fail_q <= 1'b1;
                            end
                        end
                    end
                end
            end
        end
    end

    // Storage is deliberately not reset so contents survive a reset pulse.
    always_ff @(posedge clk) begin
        if (commit && c_write && !c_err) begin
            ram[c_idx] <= c_wdata;
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign done      = done_q;
    assign fail      = fail_q;
    assign wr_count  = wr_count_q;

endmodule
